// File: rtl/magic_pkg.sv
// Shared constants for the "%PDF" magic-number detector: pattern bytes, case-fold mask, FSM encoding.
package magic_pkg;
  localparam logic [7:0] PAT0      = 8'h25;  // '%'
  localparam logic [7:0] PAT1      = 8'h50;  // 'P'
  localparam logic [7:0] PAT2      = 8'h44;  // 'D'
  localparam logic [7:0] PAT3      = 8'h46;  // 'F'
  localparam logic [7:0] FOLD_MASK = 8'h20;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;
endpackage

// File: rtl/magic_detector_if.sv
// Stream-in / status-out bundle between the file-reader stage and the magic detector.
interface magic_detector_if #(
  parameter int CNT_W = 8,
  parameter int OFS_W = 16
);
  logic             clear;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             match;
  logic             found;
  logic [OFS_W-1:0] first_offset;
  logic [CNT_W-1:0] match_count;
  logic [OFS_W-1:0] byte_count;
  logic             ofs_ovf;

  modport master (
    output clear, in_valid, in_data,
    input  match, found, first_offset, match_count, byte_count, ofs_ovf
  );

  modport slave (
    input  clear, in_valid, in_data,
    output match, found, first_offset, match_count, byte_count, ofs_ovf
  );
endinterface

// File: rtl/magic_detector_ascii_fold.sv
// Combinational case fold: lowercase ASCII letters map to uppercase when CASE_INS is set.
module ascii_fold
  import magic_pkg::*;
#(
  parameter int CASE_INS = 1
) (
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o
);
  always_comb begin
    dat_o = dat_i;
    if ((CASE_INS != 0) && (dat_i >= 8'h61) && (dat_i <= 8'h7A)) begin
      dat_o = dat_i & ~FOLD_MASK;
    end
  end
endmodule

// File: rtl/magic_detector.sv
// Scans a byte stream for "%PDF", pulsing match one cycle after the 'F' and tracking
// first-match offset plus saturating match/byte counters; all outputs registered.
module magic_detector
  import magic_pkg::*;
#(
  parameter int CASE_INS = 1,
  parameter int CNT_W    = 8,
  parameter int OFS_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  magic_detector_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [OFS_W-1:0] OFS_ONE = {{(OFS_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic             match_q;
  logic             found_q;
  logic             ofs_ovf_q;
  logic [OFS_W-1:0] first_offset_q;
  logic [OFS_W-1:0] cand_q;
  logic [CNT_W-1:0] match_count_q;
  logic [CNT_W-1:0] match_count_d;
  logic [OFS_W-1:0] byte_count_q;
  logic [OFS_W-1:0] byte_count_d;
  logic [7:0]       fold_dat;

  ascii_fold #(.CASE_INS(CASE_INS)) u_fold (
    .dat_i (bus.in_data),
    .dat_o (fold_dat)
  );

  assign byte_count_d  = (&byte_count_q)  ? byte_count_q  : byte_count_q + OFS_ONE;
  assign match_count_d = (&match_count_q) ? match_count_q : match_count_q + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S0;
      match_q        <= 1'b0;
      found_q        <= 1'b0;
      ofs_ovf_q      <= 1'b0;
      first_offset_q <= '0;
      cand_q         <= '0;
      match_count_q  <= '0;
      byte_count_q   <= '0;
    end else if (bus.clear) begin
      // Clear wins over any byte presented alongside it, including a completing 'F'.
      state_q        <= S0;
      match_q        <= 1'b0;
      found_q        <= 1'b0;
      ofs_ovf_q      <= 1'b0;
      first_offset_q <= '0;
      cand_q         <= '0;
      match_count_q  <= '0;
      byte_count_q   <= '0;
    end else begin
      match_q <= 1'b0;
      if (bus.in_valid) begin
        byte_count_q <= byte_count_d;
        ofs_ovf_q    <= ofs_ovf_q | (&byte_count_d);
        // A '%' restarts the pattern from any state; its index saturates with byte_count.
        if (fold_dat == PAT0) begin
          state_q <= S1;
          cand_q  <= byte_count_q;
        end else begin
          case (state_q)
            S1:      state_q <= (fold_dat == PAT1) ? S2 : S0;
            S2:      state_q <= (fold_dat == PAT2) ? S3 : S0;
            S3: begin
              state_q <= S0;
              if (fold_dat == PAT3) begin
                match_q       <= 1'b1;
                found_q       <= 1'b1;
                match_count_q <= match_count_d;
                if (!found_q) begin
                  first_offset_q <= cand_q;
                end
              end
            end
            default: state_q <= S0;
          endcase
        end
      end
    end
  end

  assign bus.match        = match_q;
  assign bus.found        = found_q;
  assign bus.first_offset = first_offset_q;
  assign bus.match_count  = match_count_q;
  assign bus.byte_count   = byte_count_q;
  assign bus.ofs_ovf      = ofs_ovf_q;
endmodule

// File: tb/tb_magic_detector.sv
// Scoreboard bench: three detector variants share one stream; expected match records are queued per variant.
module tb_magic_detector;
  typedef struct {
    int fo;
    int mc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  exp_t q1[$];
  exp_t q0[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  // d1: case-insensitive default; d0: exact compare; d2: tiny counters to hit saturation.
  magic_detector_if #(.CNT_W(8), .OFS_W(16)) if1 ();
  magic_detector_if #(.CNT_W(8), .OFS_W(16)) if0 ();
  magic_detector_if #(.CNT_W(2), .OFS_W(4))  if2 ();

  magic_detector #(.CASE_INS(1), .CNT_W(8), .OFS_W(16)) d1 (.clk(clk), .rst(rst), .bus(if1));
  magic_detector #(.CASE_INS(0), .CNT_W(8), .OFS_W(16)) d0 (.clk(clk), .rst(rst), .bus(if0));
  magic_detector #(.CASE_INS(1), .CNT_W(2), .OFS_W(4))  d2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic c, input logic v, input logic [7:0] d);
    if1.clear = c; if1.in_valid = v; if1.in_data = d;
    if0.clear = c; if0.in_valid = v; if0.in_data = d;
    if2.clear = c; if2.in_valid = v; if2.in_data = d;
  endtask

  task automatic put(input logic [7:0] d);
    @(negedge clk);
    set_in(1'b0, 1'b1, d);
  endtask

  task automatic idle();
    @(negedge clk);
    set_in(1'b0, 1'b0, 8'h00);
  endtask

  task automatic push_all(input int fo, input int mc);
    exp_t e;
    e.fo = fo; e.mc = mc;
    q1.push_back(e); q0.push_back(e); q2.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_match"}, int'(if1.match), 0);
    check({tag, "_found"}, int'(if1.found), 0);
    check({tag, "_fo"},    int'(if1.first_offset), 0);
    check({tag, "_mc"},    int'(if1.match_count), 0);
    check({tag, "_bc"},    int'(if1.byte_count), 0);
    check({tag, "_ovf"},   int'(if1.ofs_ovf), 0);
    check({tag, "_d2_bc"}, int'(if2.byte_count), 0);
  endtask

  task automatic chk_drained(input string tag);
    check({tag, "_q1_left"}, q1.size(), 0);
    check({tag, "_q0_left"}, q0.size(), 0);
    check({tag, "_q2_left"}, q2.size(), 0);
    q1.delete(); q0.delete(); q2.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && if1.match) begin
      if (q1.size() == 0) check("d1_extra_match", 1, 0);
      else begin
        e = q1.pop_front();
        check("d1_fo", int'(if1.first_offset), e.fo);
        check("d1_mc", int'(if1.match_count), e.mc);
      end
    end
    if (!rst && if0.match) begin
      if (q0.size() == 0) check("d0_extra_match", 1, 0);
      else begin
        e = q0.pop_front();
        check("d0_fo", int'(if0.first_offset), e.fo);
        check("d0_mc", int'(if0.match_count), e.mc);
      end
    end
    if (!rst && if2.match) begin
      if (q2.size() == 0) check("d2_extra_match", 1, 0);
      else begin
        e = q2.pop_front();
        check("d2_fo", int'(if2.first_offset), e.fo);
        check("d2_mc", int'(if2.match_count), e.mc);
      end
    end
  end

  initial begin
    logic [7:0] s35 [9];
    logic [7:0] s36 [5];
    exp_t e;
    s35 = '{8'h00, 8'h25, 8'h70, 8'h64, 8'h66, 8'h25, 8'h50, 8'h44, 8'h46};
    s36 = '{8'h25, 8'h25, 8'h50, 8'h44, 8'h46};
    set_in(1'b0, 1'b0, 8'h00);
    #1;
    chk_zero("reset");

    // Basic match and one-cycle latency.
    do_reset();
    push_all(0, 1);
    put(8'h25); put(8'h50); put(8'h44); put(8'h46);
    idle();
    check("basic_pulse", int'(if1.match), 1);
    idle();
    check("basic_pulse_end", int'(if1.match), 0);
    check("basic_found", int'(if1.found), 1);
    check("basic_fo", int'(if1.first_offset), 0);
    check("basic_mc", int'(if1.match_count), 1);
    check("basic_bc", int'(if1.byte_count), 4);
    chk_drained("basic");

    // Lowercase occurrence only counts when case-insensitive.
    do_reset();
    push_all(1, 1);
    e.fo = 1; e.mc = 2; q1.push_back(e); q2.push_back(e);
    q0.delete(); e.fo = 5; e.mc = 1; q0.push_back(e);
    foreach (s35[i]) put(s35[i]);
    idle(); idle();
    check("case_d1_mc", int'(if1.match_count), 2);
    check("case_d1_fo", int'(if1.first_offset), 1);
    check("case_d0_mc", int'(if0.match_count), 1);
    check("case_d0_fo", int'(if0.first_offset), 5);
    check("case_bc", int'(if0.byte_count), 9);
    chk_drained("case");

    // Overlap with valid gaps.
    do_reset();
    push_all(1, 1);
    foreach (s36[i]) begin put(s36[i]); idle(); end
    idle();
    check("gap_mc", int'(if1.match_count), 1);
    check("gap_fo", int'(if1.first_offset), 1);
    check("gap_bc", int'(if1.byte_count), 5);
    chk_drained("gap");

    // Clear overrides a completing 'F'.
    do_reset();
    put(8'h25); put(8'h50); put(8'h44);
    @(negedge clk);
    set_in(1'b1, 1'b1, 8'h46);
    idle();
    chk_zero("clear");
    push_all(0, 1);
    put(8'h25); put(8'h50); put(8'h44); put(8'h46);
    idle(); idle();
    check("clear_after_fo", int'(if1.first_offset), 0);
    check("clear_after_bc", int'(if1.byte_count), 4);
    chk_drained("clear");

    // Six back-to-back matches: d2 match_count and byte_count saturate.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      e.fo = 0; e.mc = k;
      q1.push_back(e); q0.push_back(e);
      e.mc = (k > 3) ? 3 : k;
      q2.push_back(e);
    end
    for (int k = 0; k < 6; k++) begin
      put(8'h25); put(8'h50); put(8'h44); put(8'h46);
    end
    idle(); idle();
    check("sat_d2_mc", int'(if2.match_count), 3);
    check("sat_d1_mc", int'(if1.match_count), 6);
    check("sat_d2_bc", int'(if2.byte_count), 15);
    check("sat_d2_ovf", int'(if2.ofs_ovf), 1);
    check("sat_d1_ovf", int'(if1.ofs_ovf), 0);
    check("sat_d1_bc", int'(if1.byte_count), 24);
    chk_drained("sat");

    // Async reset mid-pattern.
    do_reset();
    put(8'h25); put(8'h50);
    @(negedge clk);
    set_in(1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    put(8'h44); put(8'h46);
    idle(); idle();
    check("midrst_found", int'(if1.found), 0);
    check("midrst_mc", int'(if1.match_count), 0);
    check("midrst_bc", int'(if1.byte_count), 2);
    chk_drained("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/magic_detector.md
MAGIC_DETECTOR -- requirements
Module: magic_detector

Interface
REQ-001 Parameter CASE_INS, default 1, meaning 1 = letters compared case-insensitively, 0 = exact byte compare.
REQ-002 Parameter CNT_W, default 8, meaning width of match counter.
REQ-003 Parameter OFS_W, default 16, meaning width of byte index and offset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clear  input  1  synchronous restart of detection, counters and flags.
REQ-007 in_valid  input  1  in_data carries a stream byte this cycle.
REQ-008 in_data  input  8  stream byte from the file-reader stage.
REQ-009 match  output  1  one-cycle pulse per completed "%PDF" occurrence.
REQ-010 found  output  1  sticky; at least one match since reset/clear.
REQ-011 first_offset  output  OFS_W  byte index of the '%' of the first match.
REQ-012 match_count  output  CNT_W  number of matches, saturating.
REQ-013 byte_count  output  OFS_W  number of accepted bytes, saturating.
REQ-014 ofs_ovf  output  1  sticky; byte_count reached all-ones.

Function
REQ-015 Pattern is 0x25 0x50 0x44 0x46 ("%PDF"); with CASE_INS=1, 0x70/0x64/0x66 also accepted at positions 2-4.
REQ-016 Byte accepted only when in_valid=1 and clear=0; no state changes otherwise.
REQ-017 FSM states S0 (none matched), S1 ('%'), S2 ("%P"), S3 ("%PD").
REQ-018 Transitions on accepted byte: expected next byte -> advance; '%' in any state -> S1; any other byte -> S0.
REQ-019 S3 plus 'F'/'f' -> match asserted next cycle, state S0.
REQ-020 Overlapping occurrences are detected, e.g. "%%PDF" yields one match, at index 1.
REQ-021 Index of each '%' accepted in S0..S3 latched as candidate offset; on the first match, first_offset <= candidate, found <= 1.
REQ-022 Latency: match, found, match_count and first_offset update in the cycle after the 'F' is accepted (registered outputs).
REQ-023 match_count increments per match, holds at all-ones.
REQ-024 byte_count increments per accepted byte, holds at all-ones; ofs_ovf set when all-ones reached.
REQ-025 After ofs_ovf, detection continues; candidate offsets saturate at all-ones.
REQ-026 clear=1: state S0, all counters, flags and first_offset to 0 next cycle; byte in same cycle discarded; clear overrides a completing match (no pulse).
REQ-027 match deasserts the cycle after its pulse unless another match completes (minimum spacing is 4 accepted bytes).
REQ-028 Gaps in in_valid do not alter partial-match progress.

Reset
REQ-029 rst=1 asynchronously forces S0, match=0, found=0, first_offset=0, match_count=0, byte_count=0, ofs_ovf=0, candidate=0.
REQ-030 Release of rst is synchronous to clk; the first byte is accepted on the first rising edge with rst=0.

Structure
REQ-031 Package magic_pkg holds the four pattern byte constants, the case-fold mask 0x20, and the FSM state encoding.
REQ-032 One sub-module, ascii_fold, combinational: maps 0x61-0x7A to 0x41-0x5A when CASE_INS=1, else passthrough.
REQ-033 No memories; all state in flops.

Verification
REQ-034 Reset then bytes 25 50 44 46 on consecutive cycles -> match pulses 1 cycle after 46, found=1, first_offset=0, match_count=1, byte_count=4.
REQ-035 CASE_INS=1, bytes 00 25 70 64 66 25 50 44 46 -> two pulses, first_offset=1, match_count=2; CASE_INS=0 -> one pulse, first_offset=5.
REQ-036 Bytes 25 25 50 44 46 with in_valid low every other cycle -> one match, first_offset=1, byte_count=5.
REQ-037 Bytes 25 50 44, then clear with in_valid=1 and data 46 -> no match, all outputs 0; next 25 50 44 46 -> first_offset=0.
REQ-038 CNT_W=2, six back-to-back "%PDF" -> match_count holds 3, six pulses observed.
REQ-039 rst asserted mid-pattern after 25 50 -> outputs 0 immediately; following 44 46 produces no match.
